// File: rtl/restoring_divider_seq_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The core issues divides through the master modport; the divider is the slave.
interface restoring_divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_seq.sv
// Multi-cycle restoring divider: one quotient bit per clock, with divide-by-zero reporting.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module restoring_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    r,
  restoring_divider_seq_if.slave  div_if
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] res_quo_d;
  logic [WIDTH-1:0] res_rem_d;
  logic [WIDTH-1:0] dbz_rem_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic             accept;

  assign accept = div_if.start && (state_q != RUN);

  // quo_q starts as the dividend and shifts out MSB-first while quotient bits shift in
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, div_q};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
`ifdef DIVIDER_SIGNED_EN
    res_quo_d = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
    res_rem_d = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
    dbz_rem_d = neg_rem_q ? (~quo_q + 1'b1) : quo_q;
    a_mag_d   = div_if.dividend[WIDTH-1] ? (~div_if.dividend + 1'b1) : div_if.dividend;
    b_mag_d   = div_if.divisor[WIDTH-1]  ? (~div_if.divisor + 1'b1)  : div_if.divisor;
`else
    res_quo_d = quo_d;
    res_rem_d = rem_d;
    dbz_rem_d = quo_q;
    a_mag_d   = div_if.dividend;
    b_mag_d   = div_if.divisor;
`endif
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= IDLE;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          // A zero divisor magnitude only arises from a zero divisor, so skip the loop
          if (div_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= dbz_rem_d;
            dbz_q       <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              quotient_q  <= res_quo_d;
              remainder_q <= res_rem_d;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= DONE;
            end
          end
        end
        default: begin
          if (accept) begin
            div_q     <= b_mag_d;
            quo_q     <= a_mag_d;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            state_q   <= RUN;
`ifdef DIVIDER_SIGNED_EN
            neg_quo_q <= div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
            neg_rem_q <= div_if.dividend[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quotient_q;
  assign div_if.remainder   = remainder_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed-vector and random-sweep bench for restoring_divider_seq at WIDTH=32 and WIDTH=8.
// Expected values follow DIVIDER_SIGNED_EN when the macro is defined.
module tb_restoring_divider_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] rm;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic r;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  restoring_divider_seq_if #(.WIDTH(32)) bus32 ();
  restoring_divider_seq_if #(.WIDTH(8))  bus8 ();

  restoring_divider_seq #(.WIDTH(32)) dut32 (.clk(clk), .r(r), .div_if(bus32));
  restoring_divider_seq #(.WIDTH(8))  dut8  (.clk(clk), .r(r), .div_if(bus8));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one divide on the selected instance and wait (bounded) for done
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] q, output logic [31:0] rm,
                               output logic dbz, output int lat);
    logic seen;
    @(negedge clk);
    if (sel == 0) begin
      bus32.start = 1'b1; bus32.dividend = a; bus32.divisor = b;
    end else begin
      bus8.start = 1'b1; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus8.start  = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(posedge clk); #1;
      lat++;
      seen = (sel == 0) ? bus32.done : bus8.done;
    end
    if (!seen) lat = -1;
    if (sel == 0) begin
      q = bus32.quotient; rm = bus32.remainder; dbz = bus32.div_by_zero;
    end else begin
      q = {24'd0, bus8.quotient}; rm = {24'd0, bus8.remainder}; dbz = bus8.div_by_zero;
    end
  endtask

  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] rm, output logic dbz);
    logic [31:0] mask;
    longint      sa, sb, sq, sr;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    dbz  = 1'b0;
    if ((b & mask) == 32'd0) begin
      q = mask; rm = a & mask; dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = (w == 32) ? longint'($signed(a)) : longint'($signed(a[7:0]));
      sb = (w == 32) ? longint'($signed(b)) : longint'($signed(b[7:0]));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0] & mask;
      rm = sr[31:0] & mask;
`else
      sa = 0; sb = 0; sq = 0; sr = 0;
      q  = (a & mask) / (b & mask);
      rm = (a & mask) % (b & mask);
`endif
    end
  endfunction

  initial begin
    logic [31:0] q, rm, a, b, eq, erm;
    logic        dbz, edbz;
    int          lat;

    vecs.push_back('{32'd108,        32'd31, 32'd3,          32'd15,   1'b0, 32});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0,    1'b0, 32});
    vecs.push_back('{32'd5,          32'd7,  32'd0,          32'd5,    1'b0, 32});
    vecs.push_back('{32'd1234,       32'd0,  32'hFFFF_FFFF,  32'd1234, 1'b1, 1});
    vecs.push_back('{32'd10,         32'd2,  32'd5,          32'd0,    1'b0, 32});
    vecs.push_back('{32'd100,        32'd7,  32'd14,         32'd2,    1'b0, 32});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FF94,  32'd31,         32'hFFFF_FFFD, 32'hFFFF_FFF1, 1'b0, 32});
    vecs.push_back('{32'd108,        32'hFFFF_FFE1,  32'hFFFF_FFFD, 32'd15,        1'b0, 32});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 32});
`endif

    r = 1'b1;
    bus32.start = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.start  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {63'd0, bus32.busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus32.done}, 64'd0);
    checkOutput("reset_quotient", {32'd0, bus32.quotient}, 64'd0);
    checkOutput("reset_remainder", {32'd0, bus32.remainder}, 64'd0);
    checkOutput("reset_dbz", {63'd0, bus32.div_by_zero}, 64'd0);
    @(negedge clk);
    r = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, q, rm, dbz, lat);
      $display("[TB] vector %0d: 0x%0h / 0x%0h -> q=0x%0h r=0x%0h", i, vecs[i].a, vecs[i].b, q, rm);
      checkOutput($sformatf("vec%0d_quotient", i), {32'd0, q}, {32'd0, vecs[i].q});
      checkOutput($sformatf("vec%0d_remainder", i), {32'd0, rm}, {32'd0, vecs[i].rm});
      checkOutput($sformatf("vec%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_busy_at_done", i), {63'd0, bus32.busy}, 64'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {63'd0, bus32.done}, 64'd0);
    end

    // Start raised mid-divide is ignored; then back-to-back start in the done cycle
    @(negedge clk);
    bus32.start = 1'b1; bus32.dividend = 32'd108; bus32.divisor = 32'd31;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    lat = 0;
    while (lat < 100 && !bus32.done) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        bus32.start = 1'b1; bus32.dividend = 32'd9; bus32.divisor = 32'd3;
      end
      if (lat == 6) bus32.start = 1'b0;
    end
    checkOutput("ignore_latency", 64'(lat), 64'd32);
    checkOutput("ignore_quotient", {32'd0, bus32.quotient}, 64'd3);
    checkOutput("ignore_remainder", {32'd0, bus32.remainder}, 64'd15);
    bus32.start = 1'b1; bus32.dividend = 32'd9; bus32.divisor = 32'd3;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    checkOutput("b2b_done_dropped", {63'd0, bus32.done}, 64'd0);
    checkOutput("b2b_busy", {63'd0, bus32.busy}, 64'd1);
    checkOutput("b2b_quotient_held", {32'd0, bus32.quotient}, 64'd3);
    checkOutput("b2b_remainder_held", {32'd0, bus32.remainder}, 64'd15);
    lat = 0;
    while (lat < 100 && !bus32.done) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_latency", 64'(lat), 64'd32);
    checkOutput("b2b_quotient", {32'd0, bus32.quotient}, 64'd3);
    checkOutput("b2b_remainder", {32'd0, bus32.remainder}, 64'd0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus32.start = 1'b1; bus32.dividend = 32'd1000; bus32.divisor = 32'd3;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    r = 1'b1;
    #1;
    checkOutput("midreset_busy", {63'd0, bus32.busy}, 64'd0);
    checkOutput("midreset_done", {63'd0, bus32.done}, 64'd0);
    checkOutput("midreset_quotient", {32'd0, bus32.quotient}, 64'd0);
    checkOutput("midreset_remainder", {32'd0, bus32.remainder}, 64'd0);
    checkOutput("midreset_dbz", {63'd0, bus32.div_by_zero}, 64'd0);
    @(negedge clk);
    r = 1'b0;
    applyStimulus(0, 32'd100, 32'd7, q, rm, dbz, lat);
    checkOutput("postreset_quotient", {32'd0, q}, 64'd14);
    checkOutput("postreset_remainder", {32'd0, rm}, 64'd2);
    checkOutput("postreset_latency", 64'(lat), 64'd32);

    // Random sweep on both widths against the behavioural model
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 15; i++) begin
        a = $urandom;
        b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        if (sel == 1) begin
          a = a & 32'hFF;
          b = b & 32'hFF;
        end
        model((sel == 0) ? 32 : 8, a, b, eq, erm, edbz);
        applyStimulus(sel, a, b, q, rm, dbz, lat);
        checkOutput($sformatf("rand_w%0d_%0d_quotient", (sel == 0) ? 32 : 8, i), {32'd0, q}, {32'd0, eq});
        checkOutput($sformatf("rand_w%0d_%0d_remainder", (sel == 0) ? 32 : 8, i), {32'd0, rm}, {32'd0, erm});
        checkOutput($sformatf("rand_w%0d_%0d_dbz", (sel == 0) ? 32 : 8, i), {63'd0, dbz}, {63'd0, edbz});
        checkOutput($sformatf("rand_w%0d_%0d_latency", (sel == 0) ? 32 : 8, i), 64'(lat),
                    edbz ? 64'd1 : ((sel == 0) ? 64'd32 : 64'd8));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
